// File: rtl/bk_sub_pipe.sv
// bk_sub_pipe: two-stage pipelined subtractor with Brent-Kung prefix carry logic.
//
// Computes in_op1 - in_op2 - in_bin as in_op1 + ~in_op2 + ~in_bin. The lower
// half of the difference is produced in stage S1. The upper half is produced in
// stage S2, using the carry that S1 registered, together with the flags.
// Valid/ready handshakes are used on both sides, and the block sustains one
// transfer per cycle.
//
// Parameters
//   WIDTH      operand/result width; legal values 16, 32, 64
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_flush   synchronous clear of both pipeline stages
//   in_valid   upstream operand valid
//   out_ready  block can accept an operand this cycle (combinational)
//   in_op1     minuend
//   in_op2     subtrahend
//   in_bin     borrow in
//   out_valid  result valid to downstream
//   in_ready   downstream accepts the result
//   out_res    difference, modulo 2^WIDTH
//   out_bout   borrow out (unsigned in_op1 < in_op2 + in_bin)
//   out_ovf    signed overflow
//   out_zero   out_res is zero
`timescale 1ns/1ps

module bk_sub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_flush,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_bout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int H = WIDTH / 2;

  // H-bit Brent-Kung adder. Returns {carry_out, sum}.
  // The up-sweep builds group generates at power-of-two spans. The down-sweep
  // then fills in the remaining prefixes, so that gg[i] ends up as the carry
  // out of bit i.
  function automatic logic [H:0] bk_add(input logic [H-1:0] a,
                                        input logic [H-1:0] b,
                                        input logic         cin);
    logic [H-1:0] p;
    logic [H-1:0] gg;
    logic [H-1:0] pp;
    logic [H-1:0] s;
    p  = a ^ b;
    gg = a & b;
    pp = p;
    // The carry in is folded into bit 0, so the prefix tree yields true carries.
    gg[0] = gg[0] | (p[0] & cin);
    for (int d = 1; d < H; d = d * 2) begin
      for (int i = 2 * d - 1; i < H; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = H / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < H; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    s[0] = p[0] ^ cin;
    for (int i = 1; i < H; i++) begin
      s[i] = p[i] ^ gg[i-1];
    end
    return {gg[H-1], s};
  endfunction

  // Pipeline state
  logic             s1_valid;
  logic             s2_valid;
  logic [H-1:0]     s1_lo;
  logic             s1_c;
  logic [H-1:0]     s1_a_hi;
  logic [H-1:0]     s1_b_hi;

  // Handshake control
  logic             s2_en;
  logic             accept;

  // Stage datapath
  logic [H:0]       lo_sum;
  logic [H:0]       hi_sum;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;

  // S2 can take new data when it is empty or its result leaves this cycle.
  assign s2_en     = !s2_valid || in_ready;
  assign out_ready = !in_flush && (!s1_valid || !s2_valid || in_ready);
  assign accept    = in_valid && out_ready;
  assign out_valid = s2_valid;

  // Subtraction as addition of the inverted subtrahend. A borrow in of 0
  // becomes a carry in of 1.
  assign lo_sum   = bk_add(in_op1[H-1:0], ~in_op2[H-1:0], ~in_bin);
  assign hi_sum   = bk_add(s1_a_hi, ~s1_b_hi, s1_c);
  assign res_next = {hi_sum[H-1:0], s1_lo};
  // Overflow: the operand signs differ, and the result sign differs from the minuend's.
  assign ovf_next = (s1_a_hi[H-1] ^ s1_b_hi[H-1]) & (hi_sum[H-1] ^ s1_a_hi[H-1]);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_res  <= '0;
      out_bout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (in_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s2_en) begin
        s1_valid <= 1'b0;
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_res  <= res_next;
          out_bout <= ~hi_sum[H];
          out_ovf  <= ovf_next;
          out_zero <= (res_next == '0);
        end
      end
    end
  end

  // NOTE: the S1 data registers are deliberately left out of the reset. Their
  // contents are only consumed when s1_valid is set, and leaving them out of
  // the reset keeps the reset fan-out off the wide datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_lo   <= lo_sum[H-1:0];
      s1_c    <= lo_sum[H];
      s1_a_hi <= in_op1[WIDTH-1:H];
      s1_b_hi <= in_op2[WIDTH-1:H];
    end
  end

endmodule

// File: tb/tb_bk_sub_pipe.sv
`timescale 1ns/1ps

module tb_bk_sub_pipe;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         bout;
    logic         ovf;
    logic         zero;
  } exp_t;

  typedef struct {
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         bin;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready;
  logic [W-1:0] in_op1 = '0;
  logic [W-1:0] in_op2 = '0;
  logic         in_bin = 1'b0;
  logic         out_valid;
  logic         in_ready = 1'b0;
  logic [W-1:0] out_res;
  logic         out_bout;
  logic         out_ovf;
  logic         out_zero;

  int   checks = 0;
  int   errors = 0;
  int   rx_count = 0;
  exp_t sb[$];
  vec_t vecs[9];

  bk_sub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flush  (in_flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .out_res   (out_res),
    .out_bout  (out_bout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain wide arithmetic straight from the definitions.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t        e;
    logic [W:0]  wide;
    longint      s;
    wide   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    s      = longint'($signed(a)) - longint'($signed(b)) - longint'({63'd0, bi});
    e.res  = wide[W-1:0];
    e.bout = wide[W];
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.zero = (wide[W-1:0] == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_FFFF;
      5:       return 32'h0001_0000;
      default: return $urandom();
    endcase
  endfunction

  // One clock cycle. The caller has already set the inputs; e is the expected
  // result of the operand currently presented. The pipeline holds at most two
  // items, so the block may refuse an operand only when it holds two
  // unconsumed items and downstream is stalled, or during a flush.
  task automatic cycle(input exp_t e, output logic acc);
    #1;
    check("out_ready", 64'(out_ready),
          64'(!in_flush && !(sb.size() == 2 && !in_ready)));
    if (sb.size() == 0) begin
      check("no_stale_valid", 64'(out_valid), 64'd0);
    end else if (out_valid) begin
      check("result", 64'({out_res, out_bout, out_ovf, out_zero}), 64'(sb[0]));
    end
    acc = in_valid && out_ready;
    if (out_valid && in_ready && sb.size() > 0) begin
      void'(sb.pop_front());
      rx_count++;
    end
    if (acc) sb.push_back(e);
    @(posedge clk);
    #1;
    if (in_flush) sb.delete();
  endtask

  task automatic drain();
    logic acc;
    exp_t dummy;
    dummy    = '0;
    in_valid = 1'b0;
    in_flush = 1'b0;
    in_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) cycle(dummy, acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    in_op1   = a;
    in_op2   = b;
    in_bin   = bi;
    in_valid = 1'b1;
  endtask

  initial begin
    logic acc;
    exp_t e;
    int   sent;
    int   rx_before;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, '{32'h0000_0002, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{32'h1234_5678, 32'h1234_5677, 1'b1, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
    vecs[4] = '{32'h0001_0000, 32'h0000_0001, 1'b0, '{32'h0000_FFFF, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({out_res, out_bout, out_ovf, out_zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(out_ready), 64'd1);

    // Latency: out_valid is low after the accepting edge and high after the next one.
    in_ready = 1'b1;
    present(vecs[0].op1, vecs[0].op2, vecs[0].bin);
    cycle(vecs[0].e, acc);
    check("first_edge_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    check("latency_s1_only", 64'(out_valid), 64'd0);
    cycle(vecs[0].e, acc);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    drain();

    // Table vectors, back to back at full throughput
    for (int i = 0; i < 9; i++) begin
      present(vecs[i].op1, vecs[i].op2, vecs[i].bin);
      in_ready = 1'b1;
      cycle(vecs[i].e, acc);
      check("table_accept", 64'(acc), 64'd1);
    end
    drain();

    // Eight-operand stream, with downstream stalled for three cycles mid-stream
    rx_before = rx_count;
    sent = 0;
    for (int c = 0; c < 50 && sent < 8; c++) begin
      present(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      in_ready = !(c >= 3 && c < 6);
      e = model(in_op1, in_op2, in_bin);
      cycle(e, acc);
      if (acc) sent++;
    end
    drain();
    check("stream_received", 64'(rx_count - rx_before), 64'd8);

    // Flush with two in flight; a simultaneous operand must be refused.
    in_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      present(rand_op(), rand_op(), 1'b0);
      e = model(in_op1, in_op2, in_bin);
      cycle(e, acc);
    end
    in_flush = 1'b1;
    present(32'h5, 32'h3, 1'b0);
    cycle(vecs[0].e, acc);
    check("flush_refuses", 64'(acc), 64'd0);
    in_flush = 1'b0;
    in_valid = 1'b0;
    check("flush_clears_valid", 64'(out_valid), 64'd0);
    in_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle(vecs[0].e, acc);
    drain();

    // Asynchronous reset with two in flight
    in_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      present(rand_op(), rand_op(), 1'b1);
      e = model(in_op1, in_op2, in_bin);
      cycle(e, acc);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_outputs", 64'({out_res, out_bout, out_ovf, out_zero}), 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    present(vecs[3].op1, vecs[3].op2, vecs[3].bin);
    in_ready = 1'b1;
    cycle(vecs[3].e, acc);
    check("accept_after_reset", 64'(acc), 64'd1);
    drain();

    // Random operands with random valid/ready patterns and rare flushes
    sent = 0;
    for (int c = 0; c < 60000 && sent < 20000; c++) begin
      in_op1   = rand_op();
      in_op2   = rand_op();
      in_bin   = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      in_ready = ($urandom_range(0, 3) != 0);
      in_flush = ($urandom_range(0, 999) == 0);
      e = model(in_op1, in_op2, in_bin);
      cycle(e, acc);
      if (acc) sent++;
    end
    check("random_sent", 64'(sent), 64'd20000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
